// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit (optional MUL/DIV decode via CTRL_MULDIV_EN)
module control_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int OP_W        = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [15:0]     Rin,
  output logic [15:0]     Rout,
  output logic [OP_W-1:0] alu_op,
  output logic            run,
  output logic            fault
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_SHRA = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_ROR  = OP_W'(5'b01010);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10011);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(5'b11010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(5'b11011);
`ifdef CTRL_MULDIV_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
`endif

  // Wait counter just wide enough to reach MEM_TIMEOUT; saturates when waiting forever.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
`ifdef CTRL_MULDIV_EN
    S_T6,
`endif
    S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  logic [OP_W-1:0]  opcode;
  logic [15:0]      ra_oh, rb_oh, rc_oh;
  logic             is_bin, is_un, is_md, is_nop, is_halt, is_exec;
  logic             timeout_hit;
  logic             unused_ir;

  assign opcode    = ir[31 -: OP_W];
  assign ra_oh     = 16'd1 << ir[26:23];
  assign rb_oh     = 16'd1 << ir[22:19];
  assign rc_oh     = 16'd1 << ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == LAST_WAIT);

  // Opcode class decode; MUL/DIV only become legal when the feature is built in.
  always_comb begin
    is_bin  = 1'b0;
    is_un   = 1'b0;
    is_md   = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   is_bin  = 1'b1;
      OP_NEG, OP_NOT:                    is_un   = 1'b1;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV:                    is_md   = 1'b1;
`endif
      OP_NOP:                            is_nop  = 1'b1;
      OP_HALT:                           is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_exec = is_bin | is_un | is_md;

  // State, wait counter and sticky fault; clear wipes everything immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: fetch with bounded memory wait, then per-class execute length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0: begin
        cnt_d   = '0;
        state_d = S_T1;
      end
      S_T1, S_T1W: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else if (timeout_hit) begin
          state_d = S_HALTED;
          fault_d = 1'b1;
        end else begin
          state_d = S_T1W;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_T2: begin
        if (is_exec) begin
          state_d = S_T3;
        end else if (is_nop) begin
          state_d = S_T0;
        end else begin
          state_d = S_HALTED;
          fault_d = !is_halt;
        end
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = is_un ? S_T0 : S_T5;
`ifdef CTRL_MULDIV_EN
      S_T5: state_d = is_md ? S_T6 : S_T0;
      S_T6: state_d = S_T0;
`else
      S_T5: state_d = S_T0;
`endif
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobe decode from the registered state and the instruction fields.
  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    alu_op   = '0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_un) begin
          Rout   = rb_oh;
          Zin    = 1'b1;
          alu_op = opcode;
        end else if (is_md) begin
          Rout = ra_oh;
          Yin  = 1'b1;
        end else begin
          Rout = rb_oh;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        if (is_un) begin
          Zlowout = 1'b1;
          Rin     = ra_oh;
        end else begin
          Rout   = is_md ? rb_oh : rc_oh;
          Zin    = 1'b1;
          alu_op = opcode;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else       Rin  = ra_oh;
      end
`ifdef CTRL_MULDIV_EN
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign run   = (state_q != S_HALTED);
  assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven checks of control_sequencer strobes per cycle
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        mem_ready = 1'b0;
  logic        PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic        Zlowout, Zhighout, HIin, LOin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        run, fault;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .fault(fault)
  );

  always #5 clock = ~clock;

  // Strobe word bit order: PCout PCin MARin MDRin MDRout IRin Yin Zin Zlowout Zhighout HIin LOin IncPC Read
  localparam logic [13:0] B_PCOUT = 14'h2000, B_PCIN = 14'h1000, B_MARIN = 14'h0800;
  localparam logic [13:0] B_MDRIN = 14'h0400, B_MDROUT = 14'h0200, B_IRIN = 14'h0100;
  localparam logic [13:0] B_YIN = 14'h0080, B_ZIN = 14'h0040, B_ZLO = 14'h0020;
  localparam logic [13:0] B_ZHI = 14'h0010, B_HIIN = 14'h0008, B_LOIN = 14'h0004;
  localparam logic [13:0] B_INCPC = 14'h0002, B_READ = 14'h0001;
  localparam logic [13:0] M_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [13:0] M_T1  = B_ZLO | B_PCIN | B_READ | B_MDRIN;
  localparam logic [13:0] M_T1W = B_READ | B_MDRIN;
  localparam logic [13:0] M_T2  = B_MDROUT | B_IRIN;

  typedef struct {
    int          seq;
    logic        mr;
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        run;
    logic        fault;
  } vec_t;

  vec_t        tbl [128];
  int          n_vec = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] seq_ir [8];
  logic [52:0] act;

  assign act = {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout,
                HIin, LOin, IncPC, Read, Rin, Rout, alu_op, run, fault};

  task automatic add(input int s, input logic mr, input logic [13:0] st, input logic [15:0] ri,
                     input logic [15:0] ro, input logic [4:0] a, input logic rn, input logic f);
    tbl[n_vec] = '{s, mr, st, ri, ro, a, rn, f};
    n_vec++;
  endtask

  task automatic check(input string tag, input int idx, input logic [52:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", tag, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset", 0, {14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});
    #1 clear = 1'b1;
  endtask

  initial begin
    seq_ir[0] = 32'h28918000;  // AND R1,R2,R3, memory ready at once
    seq_ir[1] = 32'h28918000;  // AND with three wait cycles
    seq_ir[2] = 32'h28918000;  // memory never ready
    seq_ir[3] = 32'hD8000000;  // HALT
    seq_ir[4] = 32'hF8000000;  // illegal opcode
    seq_ir[5] = 32'hD0000000;  // NOP
    seq_ir[6] = 32'h9AB00000;  // NOT R5,R6
    seq_ir[7] = 32'h79A00000;  // MUL R3,R4

    add(0, 1, 14'h0, 0, 0, 0, 1, 0);
    add(0, 1, M_T0, 0, 0, 0, 1, 0);
    add(0, 1, M_T1, 0, 0, 0, 1, 0);
    add(0, 1, M_T2, 0, 0, 0, 1, 0);
    add(0, 1, B_YIN, 0, 16'h0004, 0, 1, 0);
    add(0, 1, B_ZIN, 0, 16'h0008, 5'b00101, 1, 0);
    add(0, 1, B_ZLO, 16'h0002, 0, 0, 1, 0);
    add(0, 1, M_T0, 0, 0, 0, 1, 0);

    add(1, 0, 14'h0, 0, 0, 0, 1, 0);
    add(1, 0, M_T0, 0, 0, 0, 1, 0);
    add(1, 0, M_T1, 0, 0, 0, 1, 0);
    add(1, 0, M_T1W, 0, 0, 0, 1, 0);
    add(1, 0, M_T1W, 0, 0, 0, 1, 0);
    add(1, 1, M_T1W, 0, 0, 0, 1, 0);
    add(1, 0, M_T2, 0, 0, 0, 1, 0);
    add(1, 0, B_YIN, 0, 16'h0004, 0, 1, 0);
    add(1, 0, B_ZIN, 0, 16'h0008, 5'b00101, 1, 0);
    add(1, 0, B_ZLO, 16'h0002, 0, 0, 1, 0);
    add(1, 0, M_T0, 0, 0, 0, 1, 0);

    add(2, 0, 14'h0, 0, 0, 0, 1, 0);
    add(2, 0, M_T0, 0, 0, 0, 1, 0);
    add(2, 0, M_T1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 15; k++) add(2, 0, M_T1W, 0, 0, 0, 1, 0);
    add(2, 1, 14'h0, 0, 0, 0, 0, 1);
    add(2, 1, 14'h0, 0, 0, 0, 0, 1);

    for (int s = 3; s <= 7; s++) begin
      add(s, 1, 14'h0, 0, 0, 0, 1, 0);
      add(s, 1, M_T0, 0, 0, 0, 1, 0);
      add(s, 1, M_T1, 0, 0, 0, 1, 0);
      add(s, 1, M_T2, 0, 0, 0, 1, 0);
    end
    add(3, 1, 14'h0, 0, 0, 0, 0, 0);
    add(3, 1, 14'h0, 0, 0, 0, 0, 0);
    add(4, 1, 14'h0, 0, 0, 0, 0, 1);
    add(4, 1, 14'h0, 0, 0, 0, 0, 1);
    add(5, 1, M_T0, 0, 0, 0, 1, 0);
    add(5, 1, M_T1, 0, 0, 0, 1, 0);
    add(6, 1, B_ZIN, 0, 16'h0040, 5'b10011, 1, 0);
    add(6, 1, B_ZLO, 16'h0020, 0, 0, 1, 0);
    add(6, 1, M_T0, 0, 0, 0, 1, 0);
`ifdef CTRL_MULDIV_EN
    add(7, 1, B_YIN, 0, 16'h0008, 0, 1, 0);
    add(7, 1, B_ZIN, 0, 16'h0010, 5'b01111, 1, 0);
    add(7, 1, B_ZLO | B_LOIN, 0, 0, 0, 1, 0);
    add(7, 1, B_ZHI | B_HIIN, 0, 0, 0, 1, 0);
    add(7, 1, M_T0, 0, 0, 0, 1, 0);
`else
    add(7, 1, 14'h0, 0, 0, 0, 0, 1);
    add(7, 1, 14'h0, 0, 0, 0, 0, 1);
`endif

    for (int s = 0; s < 8; s++) begin
      ir = seq_ir[s];
      do_reset();
      for (int i = 0; i < n_vec; i++) begin
        if (tbl[i].seq == s) begin
          mem_ready = tbl[i].mr;
          #1;
          check($sformatf("seq%0d", s), i,
                {tbl[i].strb, tbl[i].rin, tbl[i].rout, tbl[i].alu, tbl[i].run, tbl[i].fault});
          @(negedge clock);
        end
      end
    end

    // clear pulled low in T4 of AND: strobes drop with no clock edge, then restart
    ir = 32'h28918000;
    do_reset();
    mem_ready = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    check("async_t4", 0, {B_ZIN, 16'h0, 16'h0008, 5'b00101, 1'b1, 1'b0});
    #1 clear = 1'b0;
    #1;
    check("async_drop", 0, {14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});
    @(negedge clock);
    check("async_hold", 0, {14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});
    clear = 1'b1;
    #1;
    check("async_idle", 0, {14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});
    @(negedge clock);
    check("async_t0", 0, {M_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});
    @(negedge clock);
    check("async_t1", 0, {M_T1, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
